rsa_operand_loader: RTL



---
 rtl/rsa_operand_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rsa_operand_loader.sv
// ---------------------------------------------------------------------------
// rsa_operand_loader
//
// Assembles full-width RSA operands (N, R mod N, R^2 mod N, M) from a 32-bit
// word stream. Words arrive least-significant first. The operands are held
// in stable parallel registers that feed rsa_hw. A per-operand valid mask
// lets the controller wait until every operand has been loaded.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        asynchronous, active-high reset
//   i_start        begin loading one operand (sampled only in IDLE)
//   i_sel          operand select: 0=N_Q 1=R_N_Q 2=R2_N_Q 3=M (latched on start)
//   i_clear        abort any load; clear the loaded mask and err
//   i_s_data       stream word
//   i_s_valid      stream word valid
//   i_s_last       marks the final word of an operand
//   o_s_ready      loader accepts a word (depends on state only)
//   o_busy         high in LOAD and COMMIT
//   o_done         one-cycle pulse, operand committed
//   o_err          sticky framing error
//   o_loaded       per-operand valid bits, indexed by sel
//   o_all_loaded   all four operands valid
//   o_n_q, o_r_n_q, o_r2_n_q, o_m   assembled operands
// ---------------------------------------------------------------------------
module rsa_operand_loader #(
  parameter int OP_W   = 1024,
  parameter int WORD_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_sel,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_s_data,
  input  logic              i_s_valid,
  input  logic              i_s_last,
  output logic              o_s_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [3:0]        o_loaded,
  output logic              o_all_loaded,
  output logic [OP_W-1:0]   o_n_q,
  output logic [OP_W-1:0]   o_r_n_q,
  output logic [OP_W-1:0]   o_r2_n_q,
  output logic [OP_W-1:0]   o_m
);

  localparam int WORDS = OP_W / WORD_W;
  // One extra bit so the counter never wraps at WORDS.
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic [OP_W-1:0]    r_shadow;
  logic [OP_W-1:0]    r_op [4];
  logic [3:0]         r_loaded;
  logic               r_err;
  logic               r_done;
  // A clear seen during COMMIT is remembered and applied in the next IDLE cycle.
  logic               r_clear_pend;

  logic               w_accept_start;
  logic               w_do_clear;
  logic               w_shift;
  logic               w_frame_err;

  // Next-state and control decode.
  always_comb begin
    w_state_next   = r_state;
    w_accept_start = 1'b0;
    w_do_clear     = 1'b0;
    w_shift        = 1'b0;
    w_frame_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // clear wins over a simultaneous start.
        if (i_clear || r_clear_pend) begin
          w_do_clear = 1'b1;
        end else if (i_start) begin
          w_accept_start = 1'b1;
          w_state_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_clear) begin
          w_do_clear   = 1'b1;
          w_state_next = S_IDLE;
        end else if (i_s_valid) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_CNT) begin
            if (i_s_last) begin
              w_state_next = S_COMMIT;
            end else begin
              w_frame_err  = 1'b1;
              w_state_next = S_IDLE;
            end
          end else if (i_s_last) begin
            w_frame_err  = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Control registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sel        <= 2'd0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_loaded     <= 4'd0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_clear_pend <= 1'b0;
    end else begin
      r_done       <= (r_state == S_COMMIT);
      r_clear_pend <= (r_state == S_COMMIT) && i_clear;

      if (w_accept_start) begin
        r_sel <= i_sel;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // New words enter at the top; after WORDS shifts word 0 sits at the bottom.
      if (w_shift) begin
        r_shadow <= {i_s_data, r_shadow[OP_W-1:WORD_W]};
      end

      if (w_do_clear || w_accept_start) begin
        r_err <= 1'b0;
      end else if (w_frame_err) begin
        r_err <= 1'b1;
      end

      if (w_do_clear) begin
        r_loaded <= 4'd0;
      end else if (r_state == S_COMMIT) begin
        r_loaded[r_sel] <= 1'b1;
      end
    end
  end

  // Operand registers: only the latched selection is written, only in COMMIT.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) begin
        r_op[i] <= '0;
      end
    end else if (r_state == S_COMMIT) begin
      for (int i = 0; i < 4; i++) begin
        if (r_sel == 2'(i)) begin
          r_op[i] <= r_shadow;
        end
      end
    end
  end

  assign o_s_ready    = (r_state == S_LOAD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_loaded     = r_loaded;
  assign o_all_loaded = &r_loaded;
  assign o_n_q        = r_op[0];
  assign o_r_n_q      = r_op[1];
  assign o_r2_n_q     = r_op[2];
  assign o_m          = r_op[3];

endmodule
